// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, PRESCALE-oversampled start/data/parity/stop recovery.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority instead of the centre sample.
module uart_rx #(
   parameter int unsigned width    = 8,
   parameter int unsigned PRESCALE = 8
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             RX_IN,
   input  logic             Parity_EN,
   input  logic             Parity_type,
   output logic [width-1:0] P_Data,
   output logic             Data_valid,
   output logic             Parity_error,
   output logic             Stop_error,
   output logic             Rx_busy
);

   localparam int unsigned EW = $clog2(PRESCALE);
   localparam int unsigned BW = (width > 1) ? $clog2(width) : 1;

   localparam logic [EW-1:0] SMP_MID   = EW'(PRESCALE / 2);
   localparam logic [EW-1:0] SMP_HI    = EW'(PRESCALE / 2 + 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state, state_nxt;
   logic             rx_meta, rx_s;
   logic [EW-1:0]    edge_cnt, edge_nxt;
   logic [BW-1:0]    bit_cnt, bit_nxt;
   logic [width-1:0] shift_reg, shift_nxt;
   logic [width-1:0] data_nxt;
   logic             smp_mid;
   logic             par_en_q, par_en_nxt;
   logic             par_type_q, par_type_nxt;
   logic             par_err, par_err_nxt;
   logic             dv_nxt, pe_nxt, se_nxt;
   logic             wrap, decide, bit_val;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [EW-1:0] SMP_LO = EW'(PRESCALE / 2 - 1);
   logic smp_lo;

   // Third vote is the live sample on the decision edge itself.
   always_comb begin
      bit_val = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);
   end
`else
   always_comb begin
      bit_val = smp_mid;
   end
`endif

   always_comb begin
      state_nxt    = state;
      edge_nxt     = edge_cnt;
      bit_nxt      = bit_cnt;
      shift_nxt    = shift_reg;
      data_nxt     = P_Data;
      par_en_nxt   = par_en_q;
      par_type_nxt = par_type_q;
      par_err_nxt  = par_err;
      dv_nxt       = 1'b0;
      pe_nxt       = 1'b0;
      se_nxt       = 1'b0;
      wrap         = (edge_cnt == EDGE_LAST);
      decide       = (edge_cnt == SMP_HI);

      if (state != IDLE) begin
         edge_nxt = wrap ? '0 : edge_cnt + 1'b1;
      end

      unique case (state)
         IDLE: begin
            // The detect cycle is edge 0 of the start bit, so counting resumes at 1.
            if (!rx_s) begin
               state_nxt    = START;
               edge_nxt     = EW'(1);
               bit_nxt      = '0;
               par_err_nxt  = 1'b0;
               par_en_nxt   = Parity_EN;
               par_type_nxt = Parity_type;
            end
         end
         START: begin
            if (decide && bit_val) begin
               state_nxt = IDLE;
               edge_nxt  = '0;
            end else if (wrap) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (decide) begin
               shift_nxt[bit_cnt] = bit_val;
            end
            if (wrap) begin
               if (bit_cnt == BIT_LAST) begin
                  bit_nxt   = '0;
                  state_nxt = par_en_q ? PARITY : STOP;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (decide) begin
               par_err_nxt = (bit_val != (^shift_reg ^ par_type_q));
            end
            if (wrap) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            // Leave before the stop bit ends so a back-to-back start edge is not missed.
            if (decide) begin
               state_nxt = IDLE;
               edge_nxt  = '0;
               se_nxt    = !bit_val;
               pe_nxt    = par_err;
               if (bit_val && !par_err) begin
                  data_nxt = shift_reg;
                  dv_nxt   = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            edge_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         rx_meta      <= 1'b1;
         rx_s         <= 1'b1;
         state        <= IDLE;
         edge_cnt     <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         smp_mid      <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
         smp_lo       <= 1'b1;
`endif
         par_en_q     <= 1'b0;
         par_type_q   <= 1'b0;
         par_err      <= 1'b0;
         P_Data       <= '0;
         Data_valid   <= 1'b0;
         Parity_error <= 1'b0;
         Stop_error   <= 1'b0;
         Rx_busy      <= 1'b0;
      end else begin
         rx_meta      <= RX_IN;
         rx_s         <= rx_meta;
         state        <= state_nxt;
         edge_cnt     <= edge_nxt;
         bit_cnt      <= bit_nxt;
         shift_reg    <= shift_nxt;
         if (state != IDLE && edge_cnt == SMP_MID) begin
            smp_mid <= rx_s;
         end
`ifdef UART_RX_MAJORITY_EN
         if (state != IDLE && edge_cnt == SMP_LO) begin
            smp_lo <= rx_s;
         end
`endif
         par_en_q     <= par_en_nxt;
         par_type_q   <= par_type_nxt;
         par_err      <= par_err_nxt;
         P_Data       <= data_nxt;
         Data_valid   <= dv_nxt;
         Parity_error <= pe_nxt;
         Stop_error   <= se_nxt;
         Rx_busy      <= (state_nxt != IDLE);
      end
   end

endmodule
